// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder.
// Holds opcodes, FSM states and default widths.
package alu_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b10101;
  localparam logic [4:0] OP_COMP = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_shift(
    input logic [4:0] op
  );
    return (op == OP_SLL) ||
           (op == OP_SRL) ||
           (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift step for SLL/SRL/SRA.
// Returns the shifted value and the bit shifted out.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [4:0]       op_i,
  output logic [WIDTH-1:0] val_o,
  output logic             bit_o
);

  always_comb begin
    val_o = val_i;
    bit_o = 1'b0;
    case (op_i)
      OP_SLL: begin
        val_o = {val_i[WIDTH-2:0], 1'b0};
        bit_o = val_i[WIDTH-1];
      end
      OP_SRL: begin
        val_o = {1'b0, val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      OP_SRA: begin
        val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      default: begin
        val_o = val_i;
        bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Valid/ready front end around the ALU.
// Single-cycle arithmetic/logic, iterative bit-serial shifts.
module alu_seq_responder
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_alusel,
  input  logic [4:0]       req_aluop,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             rsp_illegal,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic [4:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   step_in, step_val;
  logic [4:0]         step_op;
  logic               step_bit;
  logic [WIDTH:0]     add_w, sub_w, cmp_w;
  logic [SHAMT_W-1:0] amt;

  // In IDLE the step shifts the incoming operand, later the working value
  assign step_in = (state_q == IDLE) ? req_a : res_q;
  assign step_op = (state_q == IDLE) ? req_aluop : op_q;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i (step_in),
    .op_i  (step_op),
    .val_o (step_val),
    .bit_o (step_bit)
  );

  assign add_w = {1'b0, req_a} + {1'b0, req_b};
  assign sub_w = {1'b0, req_a} + {1'b0, ~req_b}
               + {{WIDTH{1'b0}}, 1'b1};
  assign cmp_w = {1'b0, ~req_b}
               + {{WIDTH{1'b0}}, 1'b1};
  assign amt   = req_b[SHAMT_W-1:0];

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_aluop;
          ill_d   = 1'b0;
          carry_d = 1'b0;
          state_d = RESP;
          case (req_aluop)
            OP_ADD:  {carry_d, res_d} = add_w;
            OP_SUB:  {carry_d, res_d} = sub_w;
            OP_COMP: {carry_d, res_d} = cmp_w;
            OP_AND:  res_d = req_a & req_b;
            OP_XOR:  res_d = req_a ^ req_b;
            OP_SLL, OP_SRL, OP_SRA: begin
              if (!req_alusel) begin
                res_d   = step_val;
                carry_d = step_bit;
              end else if (amt == '0) begin
                res_d   = req_a;
              end else begin
                res_d   = req_a;
                cnt_d   = amt;
                state_d = SHIFT;
              end
            end
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
          zero_d = (res_d == '0);
        end
      end
      SHIFT: begin
        res_d   = step_val;
        carry_d = step_bit;
        zero_d  = (step_val == '0);
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == 1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_result  = res_q;
  assign rsp_carry   = carry_q;
  assign rsp_zero    = zero_q;
  assign rsp_sign    = res_q[WIDTH-1];
  assign rsp_illegal = ill_q;

endmodule
